matrix_loader: RTL and testbench
================================

# matrix_loader

Upstream loader for the matrix coprocessor. Accepts matrix elements as a byte stream over a valid/ready handshake, packs each 5x5 matrix of 8-bit elements into one RAM word, and writes operand A and operand B to consecutive addresses of the single-port operand RAM. Only after that does the operation FSM read them. Sits between the host/byte source and the RAM write port; the RAM write mux selects this block while `busy` is high.

## Interface

Parameters:
- `ELEM_W`, 8, element width in bits
- `N_ELEM`, 25, elements per matrix (5x5, row-major)
- `N_MAT`, 2, matrices per load sequence (A then B)
- `ADDR_W`, 8, RAM address width
- `WORD_W`, 256, RAM word width

Ports:
- `clock`  in  1  system clock; all state updates on its rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a load sequence; sampled only in IDLE
- `base_addr`  in  ADDR_W  RAM address for matrix A; latched on accepted `start`
- `in_valid`  in  1  `in_data` carries a valid byte
- `in_data`  in  ELEM_W  element (or checksum) byte
- `in_last`  in  1  marks final byte of the current matrix frame
- `in_ready`  out  1  loader accepts a byte this cycle
- `ram_address`  out  ADDR_W  RAM write address
- `ram_data`  out  WORD_W  packed matrix word
- `ram_wren`  out  1  RAM write enable
- `busy`  out  1  high from accepted `start` until return to IDLE
- `done`  out  1  one-cycle pulse: all N_MAT matrices written
- `error`  out  1  sticky framing/checksum error; cleared by next accepted `start`

## Operation

- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: `in_ready`=0, `busy`=0. When `start`=1: latch `base_addr`, clear element counter, matrix counter and `error`, then go to COLLECT.
- COLLECT: `in_ready`=1. Each handshake (`in_valid`&&`in_ready`) stores `in_data` at bits [ELEM_W*k+ELEM_W-1 : ELEM_W*k], where k is the element index 0..24 (k=0 is row 0/col 0 at bits [7:0]). Bits [255:200] are always 0.
- Frame end:
  - The frame ends on the byte with index N_ELEM-1.
  - `in_last` must be 1 on that byte and only on that byte.
  - Mismatch in either direction: set `error`, abort to IDLE with no write for this matrix, and do not pulse `done`.
- After a valid frame end: go to WRITE.
- WRITE: for one cycle, `ram_wren`=1, `ram_address`=latched base + matrix index (mod 2^ADDR_W), and `ram_data`=packed word. `in_ready`=0.
  - Next state is COLLECT if more matrices remain (counters cleared, packing register zeroed), otherwise DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored.
- Address wrap: `base_addr`=255 writes A to 255 and B to 0.
- `ram_address`/`ram_data` hold their last values outside WRITE; only `ram_wren` qualifies them.

## Timing

- Reset (async assert, sync-safe deassert): state=IDLE. `in_ready`, `ram_wren`, `busy`, `done` and `error` are 0. `ram_address`=0, `ram_data`=0, counters=0.
- Reset mid-sequence: no write is issued for the partial matrix.
- `start` to `in_ready`=1: 1 cycle.
- Last accepted byte to `ram_wren`=1: 1 cycle.
- Final WRITE to `done`: 1 cycle.
- With continuous `in_valid`, a full sequence from `start` to `done` takes 1 + 2×(25+1) + 1 = 54 cycles.
- `in_valid` may drop at any time; no byte is lost or duplicated.
- `in_ready` depends only on state, never combinationally on `in_valid`.

## Configuration

- `MATRIX_LOADER_CHECKSUM_EN` defined:
  - Each frame carries one extra byte after element 24; `in_last` marks this checksum byte instead.
  - The checksum must equal the sum of the 25 elements mod 256.
  - Mismatch: set `error`, abort to IDLE, no write.
  - Frame length becomes 26 bytes; sequence latency becomes 56 cycles.
- Not defined: frames are 25 bytes, and no checksum logic is synthesized.

## Test plan

- Stream A = bytes 1..25 and B = bytes 26..50, with `base_addr`=0 and `in_valid` held high.
  - Required: write to addr 0 with word[7:0]=1 and word[199:192]=25; write to addr 1 with word[7:0]=26.
  - Required: bits [255:200]=0, `done` pulse at cycle 54, `error`=0.
- `in_valid` toggled 1/0 every cycle during the same stream.
  - Required: identical RAM words; `done` at cycle 104.
- `in_last` asserted on byte 10 of A.
  - Required: `error`=1, no `ram_wren`, no `done`, return to IDLE.
  - Required: a following `start` clears `error`.
- `base_addr`=255.
  - Required: writes at 255 then 0.
  - Required: a second `start` asserted mid-sequence is ignored.
- `reset_n` pulsed low after byte 30.
  - Required: all outputs 0 immediately, no write to addr 1.
  - Required: a new sequence after reset loads correctly.
- With `MATRIX_LOADER_CHECKSUM_EN`:
  - Elements all 0x0B with checksum 0x13 (275 mod 256) → write occurs.
  - Checksum 0x14 → `error`=1 and no write.

Source files
------------

// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - packs 5x5 byte matrices from a valid/ready stream into operand RAM words
// Optional feature macro MATRIX_LOADER_CHECKSUM_EN: each frame carries a trailing sum-mod-256 byte.
module matrix_loader #(
    parameter int ELEM_W = 8,
    parameter int N_ELEM = 25,
    parameter int N_MAT  = 2,
    parameter int ADDR_W = 8,
    parameter int WORD_W = 256
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    input  logic [ELEM_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_address,
    output logic [WORD_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done,
    output logic              error
);

`ifdef MATRIX_LOADER_CHECKSUM_EN
    localparam int FRAME_LEN = N_ELEM + 1;
`else
    localparam int FRAME_LEN = N_ELEM;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam int MAT_W = $clog2(N_MAT + 1);
    localparam logic [CNT_W-1:0] ELEM_LAST  = CNT_W'(N_ELEM - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [MAT_W-1:0] MAT_LAST   = MAT_W'(N_MAT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  elem_cnt_q, elem_cnt_d;
    logic [MAT_W-1:0]  mat_cnt_q, mat_cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [WORD_W-1:0] pack_q, pack_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [WORD_W-1:0] ram_data_q, ram_data_d;
    logic              error_q, error_d;
`ifdef MATRIX_LOADER_CHECKSUM_EN
    logic [ELEM_W-1:0] csum_q, csum_d;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            elem_cnt_q    <= '0;
            mat_cnt_q     <= '0;
            base_q        <= '0;
            pack_q        <= '0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            error_q       <= 1'b0;
`ifdef MATRIX_LOADER_CHECKSUM_EN
            csum_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            elem_cnt_q    <= elem_cnt_d;
            mat_cnt_q     <= mat_cnt_d;
            base_q        <= base_d;
            pack_q        <= pack_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            error_q       <= error_d;
`ifdef MATRIX_LOADER_CHECKSUM_EN
            csum_q        <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        elem_cnt_d    = elem_cnt_q;
        mat_cnt_d     = mat_cnt_q;
        base_d        = base_q;
        pack_d        = pack_q;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        error_d       = error_q;
`ifdef MATRIX_LOADER_CHECKSUM_EN
        csum_d        = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d     = base_addr;
                    elem_cnt_d = '0;
                    mat_cnt_d  = '0;
                    pack_d     = '0;
                    error_d    = 1'b0;
`ifdef MATRIX_LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                    state_d    = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (in_valid) begin
                    // The checksum byte (index N_ELEM) is never packed into the word
                    if (elem_cnt_q <= ELEM_LAST) begin
                        pack_d[int'(elem_cnt_q)*ELEM_W +: ELEM_W] = in_data;
`ifdef MATRIX_LOADER_CHECKSUM_EN
                        csum_d = csum_q + in_data;
`endif
                    end
                    elem_cnt_d = elem_cnt_q + CNT_W'(1);
                    if (in_last != (elem_cnt_q == FRAME_LAST)) begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
`ifdef MATRIX_LOADER_CHECKSUM_EN
                    else if ((elem_cnt_q == FRAME_LAST) && (in_data != csum_q)) begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
`endif
                    else if (elem_cnt_q == FRAME_LAST) begin
                        ram_address_d = base_q + ADDR_W'(mat_cnt_q);
                        ram_data_d    = pack_d;
                        state_d       = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                mat_cnt_d  = mat_cnt_q + MAT_W'(1);
                elem_cnt_d = '0;
                pack_d     = '0;
`ifdef MATRIX_LOADER_CHECKSUM_EN
                csum_d     = '0;
`endif
                state_d    = (mat_cnt_q == MAT_LAST) ? S_DONE : S_COLLECT;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready    = (state_q == S_COLLECT);
    assign ram_wren    = (state_q == S_WRITE);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign error       = error_q;
    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;

endmodule

// File: tb/tb_matrix_loader.sv
// tb/tb_matrix_loader.sv - randomized self-checking bench for matrix_loader against a frame-level model
// Honours MATRIX_LOADER_CHECKSUM_EN when defined at compile time.
module tb_matrix_loader;

    localparam int ELEM_W = 8;
    localparam int N_ELEM = 25;
    localparam int N_MAT  = 2;
    localparam int ADDR_W = 8;
    localparam int WORD_W = 256;
`ifdef MATRIX_LOADER_CHECKSUM_EN
    localparam int FL = N_ELEM + 1;
`else
    localparam int FL = N_ELEM;
`endif

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              in_valid = 1'b0;
    logic [ELEM_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] ram_address;
    logic [WORD_W-1:0] ram_data;
    logic              ram_wren;
    logic              busy;
    logic              done;
    logic              error;

    matrix_loader #(
        .ELEM_W(ELEM_W), .N_ELEM(N_ELEM), .N_MAT(N_MAT), .ADDR_W(ADDR_W), .WORD_W(WORD_W)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [WORD_W-1:0] got, input logic [WORD_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [ADDR_W-1:0] wr_addr[$];
    logic [WORD_W-1:0] wr_data[$];
    int                done_cyc[$];

    always @(negedge clock) begin
        if (ram_wren) begin
            wr_addr.push_back(ram_address);
            wr_data.push_back(ram_data);
        end
        if (done) done_cyc.push_back(cyc);
    end

    logic [ELEM_W-1:0] frames [N_MAT][FL];
    int                last_pos [N_MAT];

    function automatic logic [ELEM_W-1:0] elem_sum(input int m);
        int s = 0;
        for (int k = 0; k < N_ELEM; k++) s += frames[m][k];
        return ELEM_W'(s % 256);
    endfunction

    // kind 0: bytes 1..50 in order; kind 1: random; kind 2: all 0x0B
    task automatic fill_frames(input int kind);
        for (int m = 0; m < N_MAT; m++) begin
            for (int k = 0; k < N_ELEM; k++) begin
                case (kind)
                    0:       frames[m][k] = ELEM_W'(m * N_ELEM + k + 1);
                    1:       frames[m][k] = ELEM_W'($urandom);
                    default: frames[m][k] = 8'h0B;
                endcase
            end
`ifdef MATRIX_LOADER_CHECKSUM_EN
            frames[m][N_ELEM] = elem_sum(m);
`endif
            last_pos[m] = FL - 1;
        end
    endtask

    // mode 0: in_valid held high; 1: toggles, first offer of each frame low; 2: random
    task automatic run_seq(input string tag, input logic [ADDR_W-1:0] base, input int mode,
                           input int rst_after, input bit spurious);
        int abort_m = N_MAT;
        int abort_k = 0;
        int exp_writes;
        int acc_total = 0;
        int e0;
        int wait_n;
        bit exp_err;
        bit stop = 1'b0;
        bit did_rst = 1'b0;
        bit rdy;
        bit v;
        bit ph;
        bit sent;
        logic [WORD_W-1:0] exp_word;

        for (int m = 0; m < N_MAT; m++) begin
            int ab = -1;
            for (int k = 0; k < FL; k++) begin
                if (ab < 0 && ((k == last_pos[m]) != (k == FL - 1))) ab = k;
            end
`ifdef MATRIX_LOADER_CHECKSUM_EN
            if (ab < 0 && frames[m][FL-1] != elem_sum(m)) ab = FL - 1;
`endif
            if (ab >= 0 && abort_m == N_MAT) begin
                abort_m = m;
                abort_k = ab;
            end
        end
        exp_err    = (abort_m < N_MAT);
        exp_writes = abort_m;

        wr_addr.delete();
        wr_data.delete();
        done_cyc.delete();

        e0        = cyc;
        start     = 1'b1;
        base_addr = base;
        @(posedge clock); #1;
        check({tag, "_err_clr"}, WORD_W'(error), '0);
        check({tag, "_busy"}, WORD_W'(busy), WORD_W'(1));
        if (spurious) base_addr = base + 8'd7;
        else start = 1'b0;

        ph = 1'b1;
        for (int m = 0; m < N_MAT && !stop; m++) begin
            for (int k = 0; k < FL && !stop; k++) begin
                if (m == abort_m && k > abort_k) begin
                    stop = 1'b1;
                    break;
                end
                sent   = 1'b0;
                wait_n = 0;
                while (!sent && !stop) begin
                    rdy      = in_ready;
                    ph       = rdy ? ~ph : 1'b1;
                    v        = (mode == 0) ? 1'b1 : (mode == 1) ? ph : ($urandom_range(3) != 0);
                    in_valid = v;
                    in_data  = frames[m][k];
                    in_last  = (k == last_pos[m]);
                    @(posedge clock); #1;
                    if (v && rdy) sent = 1'b1;
                    if (++wait_n > 60) begin
                        check({tag, "_byte_timeout"}, WORD_W'(1), '0);
                        stop = 1'b1;
                    end
                end
                acc_total++;
                if (spurious && m == 0 && k == FL - 1) start = 1'b0;
                if (acc_total == rst_after) begin
                    in_valid = 1'b0;
                    reset_n  = 1'b0;
                    #1;
                    check({tag, "_rst_outs"},
                          {ram_data, ram_address, in_ready, ram_wren, busy, done, error},
                          '0);
                    #1;
                    reset_n    = 1'b1;
                    did_rst    = 1'b1;
                    exp_writes = (acc_total >= FL) ? 1 : 0;
                    stop       = 1'b1;
                    @(posedge clock); #1;
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;

        wait_n = 0;
        while (busy && wait_n < 10) begin
            @(posedge clock); #1;
            wait_n++;
        end
        check({tag, "_idle"}, WORD_W'(busy), '0);

        check({tag, "_wr_cnt"}, WORD_W'(wr_addr.size()), WORD_W'(exp_writes));
        for (int i = 0; i < exp_writes && i < wr_addr.size(); i++) begin
            exp_word = '0;
            for (int k = 0; k < N_ELEM; k++) exp_word[k*ELEM_W +: ELEM_W] = frames[i][k];
            check($sformatf("%s_addr%0d", tag, i), WORD_W'(wr_addr[i]), WORD_W'((base + i) % 256));
            check($sformatf("%s_data%0d", tag, i), wr_data[i], exp_word);
        end
        check({tag, "_done_cnt"}, WORD_W'(done_cyc.size()), WORD_W'((exp_err || did_rst) ? 0 : 1));
        check({tag, "_error"}, WORD_W'(error), WORD_W'(exp_err && !did_rst));
        if (!exp_err && !did_rst && mode < 2 && done_cyc.size() == 1) begin
            check({tag, "_latency"}, WORD_W'(done_cyc[0] - e0 + 1),
                  WORD_W'(mode == 0 ? 1 + N_MAT * (FL + 1) + 1 : 1 + N_MAT * (2 * FL + 1) + 1));
        end
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("reset_outs", {ram_data, ram_address, in_ready, ram_wren, busy, done, error}, '0);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("idle_ready", WORD_W'(in_ready), '0);

        fill_frames(0);
        run_seq("cont", 8'd0, 0, -1, 1'b0);
        run_seq("toggle", 8'd0, 1, -1, 1'b0);

        fill_frames(0);
        last_pos[0] = 9;
        run_seq("early_last", 8'd0, 0, -1, 1'b0);

        fill_frames(0);
        run_seq("wrap", 8'd255, 0, -1, 1'b1);

        run_seq("reset_mid", 8'd0, 0, FL + 5, 1'b0);
        run_seq("after_rst", 8'd0, 0, -1, 1'b0);

        for (int t = 0; t < 6; t++) begin
            fill_frames(1);
            if ($urandom_range(2) == 0) last_pos[$urandom_range(N_MAT - 1)] = $urandom_range(FL);
`ifdef MATRIX_LOADER_CHECKSUM_EN
            if ($urandom_range(3) == 0)
                frames[$urandom_range(N_MAT - 1)][FL-1] ^= ELEM_W'($urandom_range(255, 1));
`endif
            run_seq($sformatf("rand%0d", t), ADDR_W'($urandom), 2, -1, 1'b0);
        end

`ifdef MATRIX_LOADER_CHECKSUM_EN
        fill_frames(2);
        check("csum_model", WORD_W'(frames[0][N_ELEM]), WORD_W'(8'h13));
        run_seq("csum_ok", 8'd16, 0, -1, 1'b0);
        frames[0][N_ELEM] = 8'h14;
        run_seq("csum_bad", 8'd16, 0, -1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
